// File: rtl/pi_txn_queue.sv
// pi_txn_queue
//   Posted-transaction queue between the Pi GPIO register port and the 68K
//   bus-cycle engine. Pi register writes are assembled into bus operations,
//   buffered in a FIFO, and issued in order over a valid/ack/done handshake.
//
// Ports
//   PI_CLK, RESET_n      clock (posedge) and asynchronous active-low reset
//   PI_A, PI_WR, PI_RD   Pi register select and asynchronous strobes
//   PI_D_IN              Pi write data
//   op_valid, op_addr, op_data, op_rw, op_uds_n, op_lds_n
//                        head operation presented to the bus-cycle engine
//   op_ack, op_done      engine handshake pulses; op_rdata valid with op_done
//   rd_data              last completed read data
//   txn_busy             queue non-empty
//   q_status             {full, overflow, rd_valid, 9'b0, count[3:0]}
module pi_txn_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic        PI_CLK,
    input  logic        RESET_n,
    input  logic [1:0]  PI_A,
    input  logic        PI_WR,
    input  logic        PI_RD,
    input  logic [15:0] PI_D_IN,
    output logic        op_valid,
    output logic [23:0] op_addr,
    output logic [15:0] op_data,
    output logic        op_rw,
    output logic        op_uds_n,
    output logic        op_lds_n,
    input  logic        op_ack,
    input  logic        op_done,
    input  logic [15:0] op_rdata,
    output logic [15:0] rd_data,
    output logic        txn_busy,
    output logic [15:0] q_status
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state, state_next;

    logic [1:0]    wr_sync, rd_sync;
    logic          wr_rise, rd_rise;
    logic [15:0]   data_hold, addr_lo_hold;
    logic          overflow, rd_valid;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [3:0]    count4;

    logic [23:0]   mem_addr [DEPTH];
    logic [15:0]   mem_data [DEPTH];
    logic          mem_rw   [DEPTH];
    logic          mem_uds  [DEPTH];
    logic          mem_lds  [DEPTH];

    logic          push_req, push_ok, pop, issue_ack, full;
    logic          new_byte, new_a0;
    logic [23:0]   new_addr;
    logic          new_uds, new_lds;

    // Two-flop synchronisers on the asynchronous Pi strobes
    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            wr_sync <= '0;
            rd_sync <= '0;
        end else begin
            wr_sync <= {wr_sync[0], PI_WR};
            rd_sync <= {rd_sync[0], PI_RD};
        end
    end

    assign wr_rise = wr_sync[0] & ~wr_sync[1];
    assign rd_rise = rd_sync[0] & ~rd_sync[1];

    assign full      = (count == CW'(DEPTH));
    assign push_req  = wr_rise && (PI_A == 2'd2);
    assign issue_ack = op_ack && (state == S_ISSUE);
    assign pop       = op_done && (state == S_WAIT);
    // A pop in the same cycle frees the slot the push needs, so a full queue
    // still accepts the entry when the head retires on that edge.
    assign push_ok   = push_req && (!full || pop);

    // Lane decode for the entry being pushed
    assign new_byte = PI_D_IN[8];
    assign new_a0   = addr_lo_hold[0];
    assign new_addr = {PI_D_IN[7:0], addr_lo_hold[15:1], new_byte ? new_a0 : 1'b0};
    assign new_uds  = new_byte ? new_a0  : 1'b0;
    assign new_lds  = new_byte ? ~new_a0 : 1'b0;

    always_comb begin
        count_next = count;
        if (push_ok && !pop)
            count_next = count + CW'(1);
        else if (pop && !push_ok)
            count_next = count - CW'(1);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (count_next != '0) state_next = S_ISSUE;
            S_ISSUE: if (issue_ack)        state_next = S_WAIT;
            S_WAIT:  if (pop)              state_next = (count_next != '0) ? S_ISSUE : S_IDLE;
            default:                       state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state        <= S_IDLE;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow     <= 1'b0;
            rd_valid     <= 1'b0;
            data_hold    <= '0;
            addr_lo_hold <= '0;
            rd_data      <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            if (wr_rise) begin
                unique case (PI_A)
                    2'd0: data_hold    <= PI_D_IN;
                    2'd1: addr_lo_hold <= PI_D_IN;
                    2'd2: if (!push_ok) overflow <= 1'b1;
                    2'd3: if (PI_D_IN[14]) overflow <= 1'b0;
                    default: ;
                endcase
            end

            // Set from a completing read takes priority over the Pi clear
            if (pop && mem_rw[rd_ptr]) begin
                rd_data  <= op_rdata;
                rd_valid <= 1'b1;
            end else if (rd_rise && (PI_A == 2'd0)) begin
                rd_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge PI_CLK) begin
        if (push_ok) begin
            mem_addr[wr_ptr] <= new_addr;
            mem_data[wr_ptr] <= data_hold;
            mem_rw[wr_ptr]   <= PI_D_IN[9];
            mem_uds[wr_ptr]  <= new_uds;
            mem_lds[wr_ptr]  <= new_lds;
        end
    end

    generate
        if (CW >= 4) begin : g_cnt_trunc
            assign count4 = count[3:0];
        end else begin : g_cnt_ext
            assign count4 = {{(4 - CW){1'b0}}, count};
        end
    endgenerate

    assign op_valid = (state == S_ISSUE);
    assign op_addr  = mem_addr[rd_ptr];
    assign op_data  = mem_data[rd_ptr];
    assign op_rw    = mem_rw[rd_ptr];
    assign op_uds_n = mem_uds[rd_ptr];
    assign op_lds_n = mem_lds[rd_ptr];
    assign txn_busy = (count != '0);
    assign q_status = {full, overflow, rd_valid, 9'b0, count4};

endmodule

// File: tb/tb_pi_txn_queue.sv
module tb_pi_txn_queue;

    logic        PI_CLK = 1'b0;
    logic        RESET_n;
    logic [1:0]  PI_A;
    logic        PI_WR, PI_RD;
    logic [15:0] PI_D_IN;
    logic        op_valid;
    logic [23:0] op_addr;
    logic [15:0] op_data;
    logic        op_rw, op_uds_n, op_lds_n;
    logic        op_ack, op_done;
    logic [15:0] op_rdata;
    logic [15:0] rd_data;
    logic        txn_busy;
    logic [15:0] q_status;

    int errors = 0;
    int checks = 0;

    pi_txn_queue #(.DEPTH(4), .CW(3)) dut (
        .PI_CLK(PI_CLK), .RESET_n(RESET_n), .PI_A(PI_A), .PI_WR(PI_WR),
        .PI_RD(PI_RD), .PI_D_IN(PI_D_IN), .op_valid(op_valid), .op_addr(op_addr),
        .op_data(op_data), .op_rw(op_rw), .op_uds_n(op_uds_n), .op_lds_n(op_lds_n),
        .op_ack(op_ack), .op_done(op_done), .op_rdata(op_rdata), .rd_data(rd_data),
        .txn_busy(txn_busy), .q_status(q_status)
    );

    always #5 PI_CLK = ~PI_CLK;

    task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge PI_CLK);
        PI_A = a; PI_D_IN = d; PI_WR = 1'b1;
        repeat (3) @(negedge PI_CLK);
        PI_WR = 1'b0;
        repeat (3) @(negedge PI_CLK);
    endtask

    task automatic pi_read(input logic [1:0] a);
        @(negedge PI_CLK);
        PI_A = a; PI_RD = 1'b1;
        repeat (3) @(negedge PI_CLK);
        PI_RD = 1'b0;
        repeat (3) @(negedge PI_CLK);
    endtask

    task automatic pulse(input logic a, input logic d);
        @(negedge PI_CLK);
        op_ack = a; op_done = d;
        @(negedge PI_CLK);
        op_ack = 1'b0; op_done = 1'b0;
    endtask

    task automatic test_reset;
        RESET_n = 1'b0;
        repeat (2) @(negedge PI_CLK);
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got=%b exp=0", op_valid); end
        checks++; if (txn_busy !== 1'b0) begin errors++; $display("FAIL reset_txn_busy got=%b exp=0", txn_busy); end
        checks++; if (q_status !== 16'h0000) begin errors++; $display("FAIL reset_q_status got=%h exp=0000", q_status); end
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
        RESET_n = 1'b1;
        @(negedge PI_CLK);
    endtask

    task automatic test_word_write;
        pi_write(2'd0, 16'h1234);
        pi_write(2'd1, 16'h5678);
        @(negedge PI_CLK);
        PI_A = 2'd2; PI_D_IN = 16'h0012; PI_WR = 1'b1;
        @(negedge PI_CLK);
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL ww_valid_early got=%b exp=0", op_valid); end
        @(negedge PI_CLK);
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL ww_valid_2clk got=%b exp=1", op_valid); end
        @(negedge PI_CLK);
        PI_WR = 1'b0;
        repeat (3) @(negedge PI_CLK);
        checks++; if (op_addr !== 24'h125678) begin errors++; $display("FAIL ww_addr got=%h exp=125678", op_addr); end
        checks++; if (op_data !== 16'h1234) begin errors++; $display("FAIL ww_data got=%h exp=1234", op_data); end
        checks++; if ({op_rw, op_uds_n, op_lds_n} !== 3'b000) begin errors++; $display("FAIL ww_rw_lanes got=%b exp=000", {op_rw, op_uds_n, op_lds_n}); end
        checks++; if (q_status !== 16'h0001) begin errors++; $display("FAIL ww_status got=%h exp=0001", q_status); end
        pulse(1'b1, 1'b0);
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL ww_valid_after_ack got=%b exp=0", op_valid); end
        checks++; if (txn_busy !== 1'b1) begin errors++; $display("FAIL ww_busy_wait got=%b exp=1", txn_busy); end
        pulse(1'b0, 1'b1);
        checks++; if (txn_busy !== 1'b0) begin errors++; $display("FAIL ww_busy_done got=%b exp=0", txn_busy); end
    endtask

    task automatic test_byte_read;
        pi_write(2'd1, 16'h0001);
        pi_write(2'd2, 16'h0300);
        checks++; if (op_addr !== 24'h000001) begin errors++; $display("FAIL br_addr got=%h exp=000001", op_addr); end
        checks++; if ({op_rw, op_uds_n, op_lds_n} !== 3'b110) begin errors++; $display("FAIL br_rw_lanes got=%b exp=110", {op_rw, op_uds_n, op_lds_n}); end
        pulse(1'b1, 1'b0);
        op_rdata = 16'h00AB;
        pulse(1'b0, 1'b1);
        op_rdata = 16'h0000;
        checks++; if (rd_data !== 16'h00AB) begin errors++; $display("FAIL br_rd_data got=%h exp=00ab", rd_data); end
        checks++; if (q_status !== 16'h2000) begin errors++; $display("FAIL br_status_set got=%h exp=2000", q_status); end
        pi_read(2'd0);
        checks++; if (q_status !== 16'h0000) begin errors++; $display("FAIL br_status_clr got=%h exp=0000", q_status); end
        checks++; if (rd_data !== 16'h00AB) begin errors++; $display("FAIL br_rd_data_hold got=%h exp=00ab", rd_data); end
    endtask

    task automatic test_overflow;
        pi_write(2'd1, 16'h0101);
        for (int i = 0; i < 5; i++) begin
            pi_write(2'd0, 16'h1000 + 16'(i));
            pi_write(2'd2, 16'h0000);
        end
        checks++; if (q_status !== 16'hC004) begin errors++; $display("FAIL ov_status_full got=%h exp=c004", q_status); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (op_data !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL ov_drain_data%0d got=%h exp=%h", i, op_data, 16'h1000 + 16'(i)); end
            checks++; if (op_addr !== 24'h000100) begin errors++; $display("FAIL ov_drain_addr%0d got=%h exp=000100", i, op_addr); end
            pulse(1'b1, 1'b0);
            pulse(1'b0, 1'b1);
        end
        checks++; if (q_status !== 16'h4000) begin errors++; $display("FAIL ov_status_empty got=%h exp=4000", q_status); end
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL ov_no_fifth got=%b exp=0", op_valid); end
        pi_write(2'd3, 16'h4000);
        checks++; if (q_status !== 16'h0000) begin errors++; $display("FAIL ov_clear got=%h exp=0000", q_status); end
    endtask

    task automatic test_push_pop;
        for (int i = 0; i < 4; i++) begin
            pi_write(2'd0, 16'h2000 + 16'(i));
            pi_write(2'd2, 16'h0000);
        end
        checks++; if (q_status !== 16'h8004) begin errors++; $display("FAIL pp_full got=%h exp=8004", q_status); end
        pulse(1'b1, 1'b0);
        pi_write(2'd0, 16'h2004);
        // A2 strobe whose push edge coincides with op_done
        @(negedge PI_CLK);
        PI_A = 2'd2; PI_D_IN = 16'h0000; PI_WR = 1'b1;
        @(negedge PI_CLK);
        op_done = 1'b1;
        @(negedge PI_CLK);
        op_done = 1'b0;
        @(negedge PI_CLK);
        PI_WR = 1'b0;
        repeat (3) @(negedge PI_CLK);
        checks++; if (q_status !== 16'h8004) begin errors++; $display("FAIL pp_count got=%h exp=8004", q_status); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (op_data !== 16'h2000 + 16'(i)) begin errors++; $display("FAIL pp_order%0d got=%h exp=%h", i, op_data, 16'h2000 + 16'(i)); end
            pulse(1'b1, 1'b0);
            pulse(1'b0, 1'b1);
        end
        checks++; if (q_status !== 16'h0000) begin errors++; $display("FAIL pp_empty got=%h exp=0000", q_status); end
    endtask

    task automatic test_reset_midop;
        pi_write(2'd2, 16'h0000);
        pulse(1'b1, 1'b0);
        @(negedge PI_CLK);
        RESET_n = 1'b0;
        #1;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b exp=0", op_valid); end
        checks++; if (txn_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", txn_busy); end
        checks++; if (q_status !== 16'h0000) begin errors++; $display("FAIL rm_status got=%h exp=0000", q_status); end
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL rm_rd_data got=%h exp=0000", rd_data); end
        @(negedge PI_CLK);
        RESET_n = 1'b1;
        op_rdata = 16'h5555;
        pulse(1'b0, 1'b1);
        op_rdata = 16'h0000;
        checks++; if (q_status !== 16'h0000) begin errors++; $display("FAIL rm_done_ignored got=%h exp=0000", q_status); end
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL rm_rd_ignored got=%h exp=0000", rd_data); end
    endtask

    task automatic test_spurious;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        checks++; if ({op_valid, q_status} !== 17'h0) begin errors++; $display("FAIL sp_empty got=%h exp=00000", {op_valid, q_status}); end
        pi_write(2'd0, 16'h3000);
        pi_write(2'd2, 16'h0000);
        pi_write(2'd0, 16'h3001);
        pi_write(2'd2, 16'h0000);
        pulse(1'b0, 1'b1);
        checks++; if (q_status !== 16'h0002) begin errors++; $display("FAIL sp_done_issue_cnt got=%h exp=0002", q_status); end
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL sp_done_issue_valid got=%b exp=1", op_valid); end
        checks++; if (op_data !== 16'h3000) begin errors++; $display("FAIL sp_done_issue_head got=%h exp=3000", op_data); end
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        checks++; if (q_status !== 16'h0001) begin errors++; $display("FAIL sp_ackdone_cnt got=%h exp=0001", q_status); end
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL sp_ackdone_valid got=%b exp=1", op_valid); end
        checks++; if (op_data !== 16'h3001) begin errors++; $display("FAIL sp_ackdone_head got=%h exp=3001", op_data); end
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        checks++; if (txn_busy !== 1'b0) begin errors++; $display("FAIL sp_final_busy got=%b exp=0", txn_busy); end
    endtask

    initial begin
        RESET_n = 1'b0; PI_A = '0; PI_WR = 1'b0; PI_RD = 1'b0; PI_D_IN = '0;
        op_ack = 1'b0; op_done = 1'b0; op_rdata = '0;
        test_reset();
        test_word_write();
        test_byte_read();
        test_overflow();
        test_push_pop();
        test_reset_midop();
        test_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
